// File: rtl/img2col_addr_gen_pkg.sv
// Shared geometry for the im2col address generator: default feature-map/kernel sizes,
// address width and the derived output-map dimensions.
package img2col_addr_gen_pkg;

  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int K_R         = 5;
  localparam int K_S         = 5;
  localparam int SRAM_ADDR_W = 16;

  localparam int OUT_W = IMG_W - K_S + 1;
  localparam int OUT_H = IMG_H - K_R + 1;

  // Width of each loop counter; comfortably covers any image that fits the address space.
  localparam int CNT_W = 16;

endpackage

// File: rtl/img2col_addr_gen_if.sv
// Start/base request plus valid/ready address stream between the generator and the systolic side.
// Signal names follow the generator's view (_i driven into it, _o driven by it).
interface img2col_addr_gen_if
  import img2col_addr_gen_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) ();

  logic              start_i;
  logic              systolic_ready_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              valid_o;
  logic [ADDR_W-1:0] sram_rd_addr_o;
  logic              last_out_o;

  modport master (
    input  start_i,
    input  systolic_ready_i,
    input  base_addr_i,
    output valid_o,
    output sram_rd_addr_o,
    output last_out_o
  );

  modport slave (
    output start_i,
    output systolic_ready_i,
    output base_addr_i,
    input  valid_o,
    input  sram_rd_addr_o,
    input  last_out_o
  );

endinterface

// File: rtl/img2col_addr_gen.sv
// Streams im2col-ordered SRAM read addresses (oy, ox, kr, ks nest); first address one cycle after start.
// Registered outputs hold stable while systolic_ready_i is low; counters advance only on valid&&ready.
module img2col_addr_gen
  import img2col_addr_gen_pkg::*;
#(
  parameter int IMG_W       = img2col_addr_gen_pkg::IMG_W,
  parameter int IMG_H       = img2col_addr_gen_pkg::IMG_H,
  parameter int K_R         = img2col_addr_gen_pkg::K_R,
  parameter int K_S         = img2col_addr_gen_pkg::K_S,
  parameter int SRAM_ADDR_W = img2col_addr_gen_pkg::SRAM_ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_async_i,
  img2col_addr_gen_if.master bus
);

  localparam int OUT_COLS = IMG_W - K_S + 1;
  localparam int OUT_ROWS = IMG_H - K_R + 1;

  localparam logic [CNT_W-1:0] OY_MAX  = CNT_W'(OUT_ROWS - 1);
  localparam logic [CNT_W-1:0] OX_MAX  = CNT_W'(OUT_COLS - 1);
  localparam logic [CNT_W-1:0] KR_MAX  = CNT_W'(K_R - 1);
  localparam logic [CNT_W-1:0] KS_MAX  = CNT_W'(K_S - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [SRAM_ADDR_W-1:0] ADDR_ONE = SRAM_ADDR_W'(1);
  localparam logic [SRAM_ADDR_W-1:0] ROW_STEP = SRAM_ADDR_W'(IMG_W);
  // Last window of a row -> first window of the next row: +IMG_W-(OUT_COLS-1) = +K_S.
  localparam logic [SRAM_ADDR_W-1:0] WIN_WRAP = SRAM_ADDR_W'(K_S);
  localparam logic                   ONE_ELEM = (OUT_ROWS == 1) && (OUT_COLS == 1) &&
                                                (K_R == 1) && (K_S == 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       oy_q, oy_d, ox_q, ox_d, kr_q, kr_d, ks_q, ks_d;
  logic [SRAM_ADDR_W-1:0] win_q, win_d;   // address of current window's top-left pixel
  logic [SRAM_ADDR_W-1:0] row_q, row_d;   // address of current kernel row's first pixel
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state_q <= IDLE;
      oy_q    <= '0;
      ox_q    <= '0;
      kr_q    <= '0;
      ks_q    <= '0;
      win_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      kr_q    <= kr_d;
      ks_q    <= ks_d;
      win_q   <= win_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    kr_d    = kr_q;
    ks_d    = ks_q;
    win_d   = win_q;
    row_d   = row_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          oy_d    = '0;
          ox_d    = '0;
          kr_d    = '0;
          ks_d    = '0;
          win_d   = bus.base_addr_i;
          row_d   = bus.base_addr_i;
          addr_d  = bus.base_addr_i;
          valid_d = 1'b1;
          last_d  = ONE_ELEM;
        end
      end
      RUN: begin
        if (valid_q && bus.systolic_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            if (ks_q != KS_MAX) begin
              ks_d   = ks_q + CNT_ONE;
              addr_d = addr_q + ADDR_ONE;
            end else begin
              ks_d = '0;
              if (kr_q != KR_MAX) begin
                kr_d   = kr_q + CNT_ONE;
                row_d  = row_q + ROW_STEP;
                addr_d = row_q + ROW_STEP;
              end else begin
                kr_d = '0;
                if (ox_q != OX_MAX) begin
                  ox_d   = ox_q + CNT_ONE;
                  win_d  = win_q + ADDR_ONE;
                  row_d  = win_q + ADDR_ONE;
                  addr_d = win_q + ADDR_ONE;
                end else begin
                  ox_d   = '0;
                  oy_d   = oy_q + CNT_ONE;
                  win_d  = win_q + WIN_WRAP;
                  row_d  = win_q + WIN_WRAP;
                  addr_d = win_q + WIN_WRAP;
                end
              end
            end
            last_d = (oy_d == OY_MAX) && (ox_d == OX_MAX) &&
                     (kr_d == KR_MAX) && (ks_d == KS_MAX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.valid_o        = valid_q;
  assign bus.sram_rd_addr_o = addr_q;
  assign bus.last_out_o     = last_q;

endmodule

// File: tb/tb_img2col_addr_gen.sv
// Bench for img2col_addr_gen: a 4x4/3x3 instance and a default 28x28/5x5 instance,
// checked against a nested-loop im2col address list.
module tb_img2col_addr_gen;

  localparam int S_W = 4, S_H = 4, S_K = 3;
  localparam int L_W = 28, L_H = 28, L_K = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_s = 1'b0, ready_s = 1'b1;
  logic [15:0] base_s  = '0;
  logic        start_l = 1'b0, ready_l = 1'b1;
  logic [15:0] base_l  = '0;

  img2col_addr_gen_if #(.ADDR_W(16)) if_s ();
  img2col_addr_gen_if #(.ADDR_W(16)) if_l ();

  assign if_s.start_i          = start_s;
  assign if_s.systolic_ready_i = ready_s;
  assign if_s.base_addr_i      = base_s;
  assign if_l.start_i          = start_l;
  assign if_l.systolic_ready_i = ready_l;
  assign if_l.base_addr_i      = base_l;

  img2col_addr_gen #(.IMG_W(S_W), .IMG_H(S_H), .K_R(S_K), .K_S(S_K), .SRAM_ADDR_W(16)) dut_s (
    .clk_i(clk), .rst_async_i(rst), .bus(if_s.master)
  );
  img2col_addr_gen dut_l (
    .clk_i(clk), .rst_async_i(rst), .bus(if_l.master)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every window position, then every kernel tap, with the address written out directly.
  task automatic build_exp(input bit big, input logic [15:0] base);
    int w, h, k;
    w = big ? L_W : S_W;
    h = big ? L_H : S_H;
    k = big ? L_K : S_K;
    exp_q.delete();
    for (int oy = 0; oy <= h - k; oy++)
      for (int ox = 0; ox <= w - k; ox++)
        for (int r = 0; r < k; r++)
          for (int s = 0; s < k; s++)
            exp_q.push_back(16'(int'(base) + (oy + r) * w + (ox + s)));
  endtask

  task automatic drive(input bit big, input logic st, input logic rdy, input logic [15:0] b);
    if (big) begin start_l = st; ready_l = rdy; base_l = b; end
    else     begin start_s = st; ready_s = rdy; base_s = b; end
  endtask

  task automatic sample(input bit big, output logic v, output logic [15:0] a, output logic l);
    v = big ? if_l.valid_o        : if_s.valid_o;
    a = big ? if_l.sram_rd_addr_o : if_s.sram_rd_addr_o;
    l = big ? if_l.last_out_o     : if_s.last_out_o;
  endtask

  // Called at a negedge; returns at the negedge after the final handshake.
  task automatic run_frame(input bit big, input logic [15:0] base, input int low_pct,
                           input bit restart_mid, input bit start_at_last);
    int          idx, cyc, n;
    logic        v, l, r, st, prev_l, stalled;
    logic [15:0] a, prev_a;
    build_exp(big, base);
    n = exp_q.size();
    idx = 0; cyc = 0; stalled = 1'b0; prev_a = '0; prev_l = 1'b0;
    drive(big, 1'b1, 1'b1, base);
    @(negedge clk);
    while (idx < n && cyc < 4 * n + 50) begin
      r  = ($urandom_range(0, 99) >= low_pct);
      st = 1'b0;
      sample(big, v, a, l);
      check("valid_in_frame", {31'd0, v}, 32'd1);
      if (stalled) begin
        check("stall_addr", {16'd0, a}, {16'd0, prev_a});
        check("stall_last", {31'd0, l}, {31'd0, prev_l});
      end
      if (r) begin
        check("addr", {16'd0, a}, {16'd0, exp_q[idx]});
        check("last", {31'd0, l}, {31'd0, (idx == n - 1)});
        if (start_at_last && idx == n - 1) st = 1'b1;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1; prev_a = a; prev_l = l;
      end
      if (restart_mid && idx == 5 && r) st = 1'b1;
      drive(big, st, r, ~base);
      @(negedge clk);
      cyc++;
    end
    check("frame_done_in_budget", idx, n);
    drive(big, 1'b0, 1'b1, ~base);
    sample(big, v, a, l);
    check("valid_after_frame", {31'd0, v}, 32'd0);
    check("last_after_frame", {31'd0, l}, 32'd0);
    if (start_at_last) begin
      @(negedge clk);
      sample(big, v, a, l);
      check("start_on_last_ignored", {31'd0, v}, 32'd0);
    end
  endtask

  initial begin
    logic        v, l;
    logic [15:0] a;

    #3;
    for (int b = 0; b < 2; b++) begin
      sample(b[0], v, a, l);
      check("reset_valid", {31'd0, v}, 32'd0);
      check("reset_addr", {16'd0, a}, 32'd0);
      check("reset_last", {31'd0, l}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(1'b0, 16'd0, 0, 1'b0, 1'b1);
    @(negedge clk);
    run_frame(1'b0, 16'd100, 30, 1'b1, 1'b0);
    run_frame(1'b0, 16'hFFF8, 0, 1'b0, 1'b0);
    run_frame(1'b0, 16'd7, 30, 1'b0, 1'b0);

    // Abort a frame with an asynchronous reset between clock edges.
    drive(1'b0, 1'b1, 1'b1, 16'd40);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 16'd40);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sample(1'b0, v, a, l);
    check("midreset_valid", {31'd0, v}, 32'd0);
    check("midreset_addr", {16'd0, a}, 32'd0);
    check("midreset_last", {31'd0, l}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(1'b0, 16'd0, 20, 1'b0, 1'b0);

    run_frame(1'b1, 16'd0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/img2col_addr_gen.md
Name: img2col_addr_gen

Overview:
- Streams SRAM read addresses that unfold a single-channel feature map into im2col order for the systolic-array GEMM.
- One start pulse produces every K_R x K_S sliding-window address, window after window.
- Sits between the feature-map SRAM read port and the systolic input skew logic.
- Uses a valid/ready output handshake, so the systolic array can apply backpressure.

Parameters:
- IMG_W, 28, feature-map width in pixels (columns).
- IMG_H, 28, feature-map height in pixels (rows).
- K_R, 5, kernel rows.
- K_S, 5, kernel columns.
- SRAM_ADDR_W, 16, address width.
- Derived: OUT_W = IMG_W-K_S+1, OUT_H = IMG_H-K_R+1. Stride is fixed at 1, with no padding.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_async_i  in  1  asynchronous reset, active-high.
- start_i  in  1  single-cycle start pulse.
- systolic_ready_i  in  1  consumer ready.
- base_addr_i  in  SRAM_ADDR_W  feature-map base address; sampled only on an accepted start.
- valid_o  out  1  sram_rd_addr_o is valid.
- sram_rd_addr_o  out  SRAM_ADDR_W  read address.
- last_out_o  out  1  marks the final address of the frame.

Behaviour:
- Reset: valid_o=0, sram_rd_addr_o=0, last_out_o=0, FSM in IDLE, all counters 0. Reset mid-stream aborts the frame immediately.
- FSM states:
  - IDLE: start_i=1 latches base_addr_i, clears counters, goes to RUN.
  - RUN: valid_o=1 and the address is presented.
  - On the handshake of the last element, returns to IDLE.
- Latency: start sampled at edge N gives valid_o=1 with the first address after edge N (registered outputs). Transfer begins one cycle after start.
- Ordering uses nested counters, outermost first: oy (0..OUT_H-1), ox (0..OUT_W-1), kr (0..K_R-1), ks (0..K_S-1).
- Address: addr = base + (oy+kr)*IMG_W + (ox+ks), modulo 2^SRAM_ADDR_W (wraps silently).
- Address generation must be incremental (adders plus row/window pointer registers); no runtime multiplier.
- Handshake:
  - Counters advance only when valid_o && systolic_ready_i.
  - When not ready, valid_o, sram_rd_addr_o and last_out_o hold stable.
  - valid_o never drops mid-frame.
- last_out_o is high together with valid_o on exactly the final element (oy=OUT_H-1, ox=OUT_W-1, kr=K_R-1, ks=K_S-1). It stays high until that element is accepted, then drops with valid_o on the next edge.
- Total elements per frame: OUT_H*OUT_W*K_R*K_S.
- start_i while in RUN is ignored; base and counters are unaffected.
- start_i in the same cycle as the last handshake is also ignored. The FSM returns to IDLE, and a new start is needed.
- systolic_ready_i is a don't-care in IDLE.
- Back-to-back frames: the earliest new start is the cycle after valid_o falls.

Decomposition:
- Shared package (definitions): IMG_W, IMG_H, K_R, K_S, SRAM_ADDR_W, and the derived OUT_W/OUT_H.
- The module also takes these as parameters, defaulting to the package values, so tests can shrink the image.
- Local FSM enum {IDLE, RUN}.
- No sub-module: one counter nest plus pointer adders in a single module.

Test Plan:
- IMG 4x4, K 3x3, base 0, ready=1, start pulse → 36 addrs in 36 consecutive cycles, first valid the cycle after start:
  - Window 0: 0 1 2 4 5 6 8 9 10.
  - Window 1: 1 2 3 5 6 7 9 10 11.
  - Window 2: 4 5 6 8 9 10 12 13 14.
  - Window 3: 5 6 7 9 10 11 13 14 15.
  - last_out_o only with addr 15; valid_o=0 the cycle after.
- Same geometry, base 100, random ready with ~30% low → accepted sequence equals the previous one +100 (100..115). Address and last are stable during every stall; last_out_o coincides with addr 115 only.
- Default 28x28 with 5x5 kernel, base 0, ready=1 → exactly 576*25=14400 accepted addrs. Window 0 row 1 starts at 28. Final addr = 27*28+27 = 783, with last_out_o.
- Base 16'hFFF8, IMG 4x4, K 3x3 → addresses wrap modulo 2^16 (e.g. window 0 = FFF8 FFF9 FFFA FFFC FFFD FFFE 0000 0001 0002).
- start_i re-pulsed during RUN with a different base_addr_i → ignored; stream continues unchanged. A start in the cycle after completion runs a new frame.
- Assert rst_async_i mid-frame, asynchronously between edges → valid_o/last_out_o/addr go to 0 immediately. After release, the next start restarts from window 0.
